// File: rtl/daq_pkg.sv
// Shared widths, FIFO sizing and the per-channel measurement state encoding.
package daq_pkg;
    localparam int CNT_W      = 64;
    localparam int WORD_W     = 32;
    localparam int FIFO_DEPTH = 16;
    localparam int PTR_W      = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_FIRST = 2'd1,
        MEASURE    = 2'd2
    } state_t;
endpackage

// File: rtl/daq_channel.sv
// One measurement channel: reference-edge detect, period counter/FSM,
// 16x64 result FIFO and a two-word (high then low) AXI4-Stream serializer.
module daq_channel
    import daq_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_arm,
    input  logic              i_arm_d,
    input  logic              i_sel,
    input  logic              i_a,
    input  logic              i_a_d,
    input  logic              i_z,
    input  logic              i_z_d,
    input  logic              i_tready,
    output logic [CNT_W-1:0]  o_cnt,
    output logic              o_valid,
    output logic              o_ready,
    output logic              o_overflow,
    output logic              o_tvalid,
    output logic [WORD_W-1:0] o_tdata,
    output logic              o_tlast
);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(FIFO_DEPTH);

    state_t             r_state, w_state_nxt;
    logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
    logic [CNT_W-1:0]   r_cnt_out;
    logic               r_valid;
    logic               r_ovf;
    logic [CNT_W-1:0]   r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr, r_rd_ptr;
    logic [PTR_W:0]     r_count;
    logic               r_half;

    logic               w_ref_edge, w_arm_rise, w_capture, w_sat;
    logic               w_full, w_push, w_pop;
    logic [CNT_W-1:0]   w_entry;

    assign w_ref_edge = i_sel ? (i_z & ~i_z_d) : (i_a & ~i_a_d);
    assign w_arm_rise = i_arm & ~i_arm_d;
    assign w_sat      = i_arm && (r_state == MEASURE) && (r_cnt == {CNT_W{1'b1}});

    // Next state and counter; a capture only happens on a reference edge in MEASURE
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_capture   = 1'b0;
        if (!i_arm) begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
        end else begin
            case (r_state)
                IDLE: begin
                    w_state_nxt = WAIT_FIRST;
                    w_cnt_nxt   = '0;
                end
                WAIT_FIRST: begin
                    if (w_ref_edge) begin
                        w_state_nxt = MEASURE;
                        w_cnt_nxt   = CNT_W'(1);
                    end
                end
                MEASURE: begin
                    if (w_ref_edge) begin
                        w_capture = 1'b1;
                        w_cnt_nxt = CNT_W'(1);
                    end else if (r_cnt != {CNT_W{1'b1}}) begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                end
            endcase
        end
    end

    // State and running counter registers
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Captured result, one-cycle valid pulse and sticky overflow
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_cnt_out <= '0;
            r_valid   <= 1'b0;
            r_ovf     <= 1'b0;
        end else begin
            r_valid <= w_capture;
            if (w_capture)
                r_cnt_out <= r_cnt;
            if (w_arm_rise)
                r_ovf <= 1'b0;
            else if ((w_capture && w_full && !w_pop) || w_sat)
                r_ovf <= 1'b1;
        end
    end

    // A pop in the same cycle frees the slot, so a full FIFO still accepts the push
    assign w_full  = (r_count == FULL_CNT);
    assign w_pop   = o_tvalid && i_tready && r_half;
    assign w_push  = w_capture && (!w_full || w_pop);
    assign w_entry = r_mem[r_rd_ptr];

    // FIFO pointers, occupancy and word-phase of the entry at the head
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_half   <= 1'b0;
        end else begin
            if (w_push)
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            if (w_push && !w_pop)
                r_count <= r_count + (PTR_W + 1)'(1);
            else if (!w_push && w_pop)
                r_count <= r_count - (PTR_W + 1)'(1);
            if (o_tvalid && i_tready)
                r_half <= ~r_half;
        end
    end

    // Result storage; contents need no reset since occupancy gates the output
    always_ff @(posedge i_clk) begin
        if (w_push)
            r_mem[r_wr_ptr] <= r_cnt;
    end

    assign o_cnt      = r_cnt_out;
    assign o_valid    = r_valid;
    assign o_overflow = r_ovf;
    assign o_ready    = (r_count != '0);
    assign o_tvalid   = o_ready;
    assign o_tlast    = o_tvalid & r_half;
    assign o_tdata    = !o_tvalid ? '0 :
                        (r_half ? w_entry[WORD_W-1:0] : w_entry[CNT_W-1:WORD_W]);
endmodule

// File: rtl/daq.sv
// Two-channel encoder period acquisition: input synchronizers, monitor copies
// and two independent measurement channels streaming over AXI4-Stream.
module daq
    import daq_pkg::*;
#(
    parameter int C_M00_AXIS_TDATA_WIDTH = 32,
    parameter int C_M00_AXIS_START_COUNT = 32
) (
    input  logic                                m00_axis_aclk,
    input  logic                                m00_axis_aresetn,
    input  logic                                m01_axis_aclk,
    input  logic                                m01_axis_aresetn,
    input  logic                                ENC_CLK,
    input  logic                                I_ARM,
    input  logic                                I_SEL,
    input  logic                                I_A0,
    input  logic                                I_A1,
    input  logic                                I_Z0,
    input  logic                                I_Z1,
    output logic                                O_ARM,
    output logic                                O_SEL,
    output logic                                O_A0,
    output logic                                O_A1,
    output logic                                O_Z0,
    output logic                                O_Z1,
    output logic [CNT_W-1:0]                    O_CNT_A0,
    output logic [CNT_W-1:0]                    O_CNT_A1,
    output logic [WORD_W-1:0]                   O_CNT_A0_high,
    output logic [WORD_W-1:0]                   O_CNT_A0_low,
    output logic [WORD_W-1:0]                   O_CNT_A1_high,
    output logic [WORD_W-1:0]                   O_CNT_A1_low,
    output logic                                O_VALID_0,
    output logic                                O_VALID_1,
    output logic                                O_READY_0,
    output logic                                O_READY_1,
    output logic                                O_OVERFLOW_0,
    output logic                                O_OVERFLOW_1,
    output logic                                m00_axis_tvalid,
    output logic [C_M00_AXIS_TDATA_WIDTH-1:0]   m00_axis_tdata,
    output logic [C_M00_AXIS_TDATA_WIDTH/8-1:0] m00_axis_tstrb,
    output logic                                m00_axis_tlast,
    input  logic                                m00_axis_tready,
    output logic                                m01_axis_tvalid,
    output logic [C_M00_AXIS_TDATA_WIDTH-1:0]   m01_axis_tdata,
    output logic [C_M00_AXIS_TDATA_WIDTH/8-1:0] m01_axis_tstrb,
    output logic                                m01_axis_tlast,
    input  logic                                m01_axis_tready
);
    // Pin order in the synchronizer vectors: {Z1, Z0, A1, A0, SEL, ARM}
    logic [5:0] w_pins;
    logic [5:0] r_s1, r_s2, r_s3;
    logic       w_unused;

    assign w_pins   = {I_Z1, I_Z0, I_A1, I_A0, I_SEL, I_ARM};
    assign w_unused = &{1'b0, m01_axis_aclk, m01_axis_aresetn, ENC_CLK,
                        32'(C_M00_AXIS_START_COUNT)};

    // Two-flop synchronizer plus one delay stage for rising-edge detection
    always_ff @(posedge m00_axis_aclk) begin
        if (!m00_axis_aresetn) begin
            r_s1 <= '0;
            r_s2 <= '0;
            r_s3 <= '0;
        end else begin
            r_s1 <= w_pins;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    assign {O_Z1, O_Z0, O_A1, O_A0, O_SEL, O_ARM} = r_s2;

    daq_channel u_ch0 (
        .i_clk      (m00_axis_aclk),
        .i_rst_n    (m00_axis_aresetn),
        .i_arm      (r_s2[0]),
        .i_arm_d    (r_s3[0]),
        .i_sel      (r_s2[1]),
        .i_a        (r_s2[2]),
        .i_a_d      (r_s3[2]),
        .i_z        (r_s2[4]),
        .i_z_d      (r_s3[4]),
        .i_tready   (m00_axis_tready),
        .o_cnt      (O_CNT_A0),
        .o_valid    (O_VALID_0),
        .o_ready    (O_READY_0),
        .o_overflow (O_OVERFLOW_0),
        .o_tvalid   (m00_axis_tvalid),
        .o_tdata    (m00_axis_tdata),
        .o_tlast    (m00_axis_tlast)
    );

    daq_channel u_ch1 (
        .i_clk      (m00_axis_aclk),
        .i_rst_n    (m00_axis_aresetn),
        .i_arm      (r_s2[0]),
        .i_arm_d    (r_s3[0]),
        .i_sel      (r_s2[1]),
        .i_a        (r_s2[3]),
        .i_a_d      (r_s3[3]),
        .i_z        (r_s2[5]),
        .i_z_d      (r_s3[5]),
        .i_tready   (m01_axis_tready),
        .o_cnt      (O_CNT_A1),
        .o_valid    (O_VALID_1),
        .o_ready    (O_READY_1),
        .o_overflow (O_OVERFLOW_1),
        .o_tvalid   (m01_axis_tvalid),
        .o_tdata    (m01_axis_tdata),
        .o_tlast    (m01_axis_tlast)
    );

    assign O_CNT_A0_high  = O_CNT_A0[CNT_W-1:WORD_W];
    assign O_CNT_A0_low   = O_CNT_A0[WORD_W-1:0];
    assign O_CNT_A1_high  = O_CNT_A1[CNT_W-1:WORD_W];
    assign O_CNT_A1_low   = O_CNT_A1[WORD_W-1:0];
    assign m00_axis_tstrb = {(C_M00_AXIS_TDATA_WIDTH/8){1'b1}};
    assign m01_axis_tstrb = {(C_M00_AXIS_TDATA_WIDTH/8){1'b1}};
endmodule

// File: tb/tb_daq.sv
// Directed bench for daq: period capture, Z reference, backpressure/overflow,
// disarm/re-arm, mid-stream reset and simultaneous channel events.
module tb_daq;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        arm, sel, a0, a1, z0, z1;
    logic        tready0, tready1;
    logic        o_arm, o_sel, o_a0, o_a1, o_z0, o_z1;
    logic [63:0] cnt0, cnt1;
    logic [31:0] cnt0_hi, cnt0_lo, cnt1_hi, cnt1_lo;
    logic        vld0, vld1, rdy0, rdy1, ovf0, ovf1;
    logic        tvalid0, tvalid1, tlast0, tlast1;
    logic [31:0] tdata0, tdata1;
    logic [3:0]  tstrb0, tstrb1;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [63:0] cap0_q[$], cap1_q[$];
    int          capc0_q[$], capc1_q[$];
    logic [32:0] w0_q[$], w1_q[$];

    always #5 clk = ~clk;

    daq dut (
        .m00_axis_aclk(clk), .m00_axis_aresetn(rst_n),
        .m01_axis_aclk(clk), .m01_axis_aresetn(rst_n), .ENC_CLK(clk),
        .I_ARM(arm), .I_SEL(sel), .I_A0(a0), .I_A1(a1), .I_Z0(z0), .I_Z1(z1),
        .O_ARM(o_arm), .O_SEL(o_sel), .O_A0(o_a0), .O_A1(o_a1), .O_Z0(o_z0), .O_Z1(o_z1),
        .O_CNT_A0(cnt0), .O_CNT_A1(cnt1),
        .O_CNT_A0_high(cnt0_hi), .O_CNT_A0_low(cnt0_lo),
        .O_CNT_A1_high(cnt1_hi), .O_CNT_A1_low(cnt1_lo),
        .O_VALID_0(vld0), .O_VALID_1(vld1), .O_READY_0(rdy0), .O_READY_1(rdy1),
        .O_OVERFLOW_0(ovf0), .O_OVERFLOW_1(ovf1),
        .m00_axis_tvalid(tvalid0), .m00_axis_tdata(tdata0), .m00_axis_tstrb(tstrb0),
        .m00_axis_tlast(tlast0), .m00_axis_tready(tready0),
        .m01_axis_tvalid(tvalid1), .m01_axis_tdata(tdata1), .m01_axis_tstrb(tstrb1),
        .m01_axis_tlast(tlast1), .m01_axis_tready(tready1)
    );

    always @(posedge clk) cyc++;

    // Record captures and completed stream handshakes mid-cycle
    always @(negedge clk) begin
        if (vld0) begin cap0_q.push_back(cnt0); capc0_q.push_back(cyc); end
        if (vld1) begin cap1_q.push_back(cnt1); capc1_q.push_back(cyc); end
        if (tvalid0 && tready0) w0_q.push_back({tlast0, tdata0});
        if (tvalid1 && tready1) w1_q.push_back({tlast1, tdata1});
    end

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_q();
        cap0_q.delete(); cap1_q.delete(); capc0_q.delete(); capc1_q.delete();
        w0_q.delete(); w1_q.delete();
    endtask

    // pins = {Z1, Z0, A1, A0}
    task automatic drive_pins(input logic [3:0] pins);
        {z1, z0, a1, a0} = pins;
    endtask

    // n pulses, 3 cycles high, rising edges gap cycles apart
    task automatic pulse_train(input logic [3:0] pins, input int n, input int gap);
        for (int i = 0; i < n; i++) begin
            drive_pins(pins);
            tick(3);
            drive_pins(4'b0000);
            tick(gap - 3);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; arm = 1'b0; sel = 1'b0; drive_pins(4'b0000);
        tready0 = 1'b1; tready1 = 1'b1;
        tick(4);
        n_checks++;
        if ({tvalid0, tvalid1, tlast0, tlast1, rdy0, rdy1, vld0, vld1, ovf0, ovf1} !== 10'b0) begin
            n_fail++; $display("FAIL reset_flags: got %b required 0",
                {tvalid0, tvalid1, tlast0, tlast1, rdy0, rdy1, vld0, vld1, ovf0, ovf1});
        end
        n_checks++;
        if ({cnt0, cnt1, tdata0, tdata1} !== 192'b0) begin
            n_fail++; $display("FAIL reset_data: cnt0 %h cnt1 %h td0 %h td1 %h required 0",
                cnt0, cnt1, tdata0, tdata1);
        end
        n_checks++;
        if ({tstrb0, tstrb1} !== 8'hFF) begin
            n_fail++; $display("FAIL reset_tstrb: got %h required ff", {tstrb0, tstrb1});
        end
        rst_n = 1'b1;
        tick(2);
    endtask

    task automatic test_basic_period();
        logic [32:0] exp_w;
        arm = 1'b1; sel = 1'b0;
        tick(2);
        n_checks++;
        if ({o_arm, o_sel} !== 2'b10) begin
            n_fail++; $display("FAIL sync_copy: got %b required 10", {o_arm, o_sel});
        end
        tick(4);
        clear_q();
        pulse_train(4'b0001, 3, 10);
        tick(6);
        n_checks++;
        if (cap0_q.size() != 2) begin
            n_fail++; $display("FAIL basic_vcount: got %0d required 2", cap0_q.size());
        end
        for (int i = 0; i < cap0_q.size(); i++) begin
            n_checks++;
            if (cap0_q[i] !== 64'd10) begin
                n_fail++; $display("FAIL basic_cap[%0d]: got %0d required 10", i, cap0_q[i]);
            end
        end
        n_checks++;
        if ({cnt0_hi, cnt0_lo} !== 64'd10) begin
            n_fail++; $display("FAIL basic_hilo: got %h_%h required 0_a", cnt0_hi, cnt0_lo);
        end
        n_checks++;
        if (w0_q.size() != 4) begin
            n_fail++; $display("FAIL basic_wcount: got %0d required 4", w0_q.size());
        end
        for (int i = 0; i < w0_q.size(); i++) begin
            exp_w = (i % 2 == 0) ? {1'b0, 32'h0} : {1'b1, 32'hA};
            n_checks++;
            if (w0_q[i] !== exp_w) begin
                n_fail++; $display("FAIL basic_word[%0d]: got %h required %h", i, w0_q[i], exp_w);
            end
        end
    endtask

    task automatic test_z_reference();
        sel = 1'b1;
        tick(4);
        clear_q();
        pulse_train(4'b1000, 2, 30);
        tick(6);
        n_checks++;
        if (cap1_q.size() != 1 || cnt1 !== 64'd30) begin
            n_fail++; $display("FAIL z_cap: count %0d cnt1 %0d required 1 and 30", cap1_q.size(), cnt1);
        end
        n_checks++;
        if (cap0_q.size() != 0 || cnt0 !== 64'd10) begin
            n_fail++; $display("FAIL z_ch0_quiet: count %0d cnt0 %0d required 0 and 10", cap0_q.size(), cnt0);
        end
        n_checks++;
        if (w1_q.size() != 2 || w1_q[0] !== {1'b0, 32'h0} || w1_q[1] !== {1'b1, 32'h1E}) begin
            n_fail++; $display("FAIL z_words: got %0d words required 0,1e", w1_q.size());
        end
    endtask

    task automatic test_backpressure();
        sel = 1'b0; arm = 1'b0;
        tick(5);
        arm = 1'b1;
        tick(5);
        tready0 = 1'b0;
        clear_q();
        pulse_train(4'b0001, 17, 5);
        n_checks++;
        if ({rdy0, ovf0, tvalid0, tlast0} !== 4'b1010 || tdata0 !== 32'h0) begin
            n_fail++; $display("FAIL bp_full16: rdy/ovf/tvalid/tlast %b tdata %h required 1010 0",
                {rdy0, ovf0, tvalid0, tlast0}, tdata0);
        end
        pulse_train(4'b0001, 1, 5);
        n_checks++;
        if ({rdy0, ovf0} !== 2'b11 || cap0_q.size() != 17 || cnt0 !== 64'd5) begin
            n_fail++; $display("FAIL bp_overflow: rdy/ovf %b caps %0d cnt0 %0d required 11 17 5",
                {rdy0, ovf0}, cap0_q.size(), cnt0);
        end
        tready0 = 1'b1;
        tick(40);
        n_checks++;
        if (w0_q.size() != 32 || rdy0 !== 1'b0) begin
            n_fail++; $display("FAIL bp_drain: got %0d words ready %b required 32 0", w0_q.size(), rdy0);
        end
        for (int i = 0; i < w0_q.size(); i++) begin
            n_checks++;
            if (w0_q[i] !== ((i % 2 == 0) ? {1'b0, 32'h0} : {1'b1, 32'h5})) begin
                n_fail++; $display("FAIL bp_word[%0d]: got %h", i, w0_q[i]);
            end
        end
    endtask

    task automatic test_disarm_rearm();
        arm = 1'b0;
        tick(5);
        n_checks++;
        if (ovf0 !== 1'b1) begin
            n_fail++; $display("FAIL dis_ovf_sticky: got %b required 1", ovf0);
        end
        clear_q();
        pulse_train(4'b0001, 1, 8);
        arm = 1'b1;
        tick(5);
        n_checks++;
        if (ovf0 !== 1'b0) begin
            n_fail++; $display("FAIL rearm_ovf_clear: got %b required 0", ovf0);
        end
        pulse_train(4'b0001, 1, 8);
        arm = 1'b0;
        tick(4);
        pulse_train(4'b0001, 1, 8);
        n_checks++;
        if (cap0_q.size() != 0 || o_arm !== 1'b0) begin
            n_fail++; $display("FAIL dis_nocap: caps %0d o_arm %b required 0 0", cap0_q.size(), o_arm);
        end
        arm = 1'b1;
        tick(5);
        pulse_train(4'b0001, 2, 12);
        tick(4);
        n_checks++;
        if (cap0_q.size() != 1 || cnt0 !== 64'd12) begin
            n_fail++; $display("FAIL rearm_first: caps %0d cnt0 %0d required 1 12", cap0_q.size(), cnt0);
        end
    endtask

    task automatic test_reset_midstream();
        tready0 = 1'b0;
        pulse_train(4'b0001, 3, 6);
        tick(2);
        tready0 = 1'b1;
        tick(1);
        tready0 = 1'b0;
        rst_n = 1'b0;
        tick(1);
        n_checks++;
        if ({tvalid0, tlast0, rdy0, vld0, ovf0, o_arm, o_a0} !== 7'b0 || tdata0 !== 32'h0
            || cnt0 !== 64'h0 || tstrb0 !== 4'hF) begin
            n_fail++; $display("FAIL rst_mid: flags %b tdata %h cnt0 %h tstrb %h required 0 0 0 f",
                {tvalid0, tlast0, rdy0, vld0, ovf0, o_arm, o_a0}, tdata0, cnt0, tstrb0);
        end
        rst_n = 1'b1;
        tready0 = 1'b1;
        clear_q();
        tick(12);
        n_checks++;
        if (w0_q.size() != 0 || tvalid0 !== 1'b0) begin
            n_fail++; $display("FAIL rst_stale: got %0d words tvalid %b required 0 0", w0_q.size(), tvalid0);
        end
    endtask

    task automatic test_simultaneous();
        clear_q();
        drive_pins(4'b0010); tick(3); drive_pins(4'b0000); tick(1);
        drive_pins(4'b0001); tick(3); drive_pins(4'b0000); tick(7);
        drive_pins(4'b0011); tick(3); drive_pins(4'b0000); tick(8);
        n_checks++;
        if (cap0_q.size() != 1 || cap1_q.size() != 1) begin
            n_fail++; $display("FAIL sim_counts: got %0d/%0d required 1/1", cap0_q.size(), cap1_q.size());
        end else begin
            n_checks++;
            if (cap0_q[0] !== 64'd10 || cap1_q[0] !== 64'd14) begin
                n_fail++; $display("FAIL sim_values: got %0d/%0d required 10/14", cap0_q[0], cap1_q[0]);
            end
            n_checks++;
            if (capc0_q[0] != capc1_q[0]) begin
                n_fail++; $display("FAIL sim_cycle: got %0d/%0d required equal", capc0_q[0], capc1_q[0]);
            end
        end
        n_checks++;
        if (w0_q.size() != 2 || w1_q.size() != 2 || w0_q[1] !== {1'b1, 32'hA} || w1_q[1] !== {1'b1, 32'hE}) begin
            n_fail++; $display("FAIL sim_words: got %0d/%0d words required 2/2 ending a/e", w0_q.size(), w1_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_basic_period();
        test_z_reference();
        test_backpressure();
        test_disarm_rearm();
        test_reset_midstream();
        test_simultaneous();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
